// File: rtl/uart_tx_engine.sv
// UART transmit engine: byte FIFO feeding an 8N1 serializer.
// Back-to-back frames chain straight from STOP into START with no idle gap.
module uart_tx_engine #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [7:0]                           wr_data,
  input  logic                                 wr_en,
  input  logic                                 clr_ovf,
  output logic                                 fifo_full,
  output logic                                 fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic                                 overflow,
  output logic                                 busy,
  output logic                                 tx_done,
  output logic                                 tx
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TMAX  = TW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          ovf_q, ovf_d, busy_q, busy_d, done_q, done_d, tx_q, tx_d;
  logic          push, pop, bit_end;
  logic [7:0]    mem [FIFO_DEPTH];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    push    = wr_en & ~full_q;
    bit_end = (timer_q == TMAX);

    timer_d = bit_end ? '0 : timer_q + TW'(1);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem[rptr_q];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Chain directly into the next frame when more data is waiting.
        if (bit_end) begin
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem[rptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    full_d  = (count_d == CFULL);
    empty_d = (count_d == '0);

    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (wr_en && full_q) ovf_d = 1'b1;

    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (timer_d == TMAX);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr_q] <= wr_data;
  end

  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: frame-level reference model checked every
// cycle, a line receiver that decodes bytes, and directed plus random stimulus.
module tb_uart_tx_engine;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam int CW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          fifo_full, fifo_empty, overflow, busy, tx_done, tx;
  logic [CW-1:0] fifo_count;

  uart_tx_engine #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .clr_ovf    (clr_ovf),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx         (tx)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO as a queue, the line as a frame with a cycle offset.
  logic [7:0] q[$];
  logic [7:0] sentQ[$];
  logic [7:0] rxLog[$];
  int         doneLog[$];
  bit         mOvf = 1'b0;
  bit         mActive = 1'b0;
  logic [7:0] mByte = 8'h00;
  int         mCyc = 0;
  bit         modelValid = 1'b0;
  int         rstEpoch = 0;
  int         cycleNo = 0;

  initial begin : modelProc
    bit wasFull;
    forever begin
      @(posedge clk);
      cycleNo++;
      if (rst) begin
        q.delete();
        sentQ.delete();
        mOvf       = 1'b0;
        mActive    = 1'b0;
        mCyc       = 0;
        modelValid = 1'b1;
        rstEpoch++;
      end else if (modelValid) begin
        wasFull = (q.size() == DEPTH);
        if (mActive && mCyc < FRAME - 1) begin
          mCyc++;
        end else if (q.size() > 0) begin
          mByte   = q.pop_front();
          sentQ.push_back(mByte);
          mActive = 1'b1;
          mCyc    = 0;
        end else begin
          mActive = 1'b0;
        end
        if (wr_en && !wasFull) q.push_back(wr_data);
        if (clr_ovf) mOvf = 1'b0;
        if (wr_en && wasFull) mOvf = 1'b1;
      end
    end
  end

  function automatic logic [CW+5:0] expVec();
    logic txE;
    txE = 1'b1;
    if (mActive) begin
      if (mCyc < CLK_DIV) txE = 1'b0;
      else if (mCyc < 9 * CLK_DIV) txE = mByte[(mCyc - CLK_DIV) / CLK_DIV];
    end
    return {txE, mActive, (mActive && mCyc == FRAME - 1), mOvf,
            (q.size() == DEPTH), (q.size() == 0), CW'(q.size())};
  endfunction

  // Every cycle after the first reset, all outputs must match the model.
  initial begin : compareProc
    logic [CW+5:0] expV, actV;
    forever begin
      @(negedge clk);
      if (modelValid) begin
        expV = expVec();
        actV = {tx, busy, tx_done, overflow, fifo_full, fifo_empty, fifo_count};
        total++;
        if (actV !== expV) begin
          bad++;
          $display("[TB] FAIL cycleCompare cycle=%0d tx/busy/done/ovf/full/empty/count got=%b required=%b",
                   cycleNo, actV, expV);
        end
      end
    end
  end

  // Independent line receiver: decodes 8N1 mid-bit and logs tx_done times.
  initial begin : rxProc
    int         rxPos, seenEpoch, k;
    logic [7:0] rxSh, expB;
    rxPos = -1;
    seenEpoch = 0;
    rxSh = 8'h00;
    forever begin
      @(negedge clk);
      if (seenEpoch != rstEpoch) begin
        seenEpoch = rstEpoch;
        rxPos = -1;
      end
      if (modelValid && !rst) begin
        if (tx_done === 1'b1) doneLog.push_back(cycleNo);
        if (rxPos < 0) begin
          if (tx === 1'b0) rxPos = 0;
        end else begin
          rxPos++;
        end
        if (rxPos >= CLK_DIV && ((rxPos - CLK_DIV / 2) % CLK_DIV) == 0) begin
          k = (rxPos - CLK_DIV / 2) / CLK_DIV;
          if (k >= 1 && k <= 8) begin
            rxSh[k-1] = tx;
          end else if (k == 9) begin
            expB = (sentQ.size() > 0) ? sentQ.pop_front() : 8'hxx;
            total++;
            if (tx !== 1'b1 || rxSh !== expB) begin
              bad++;
              $display("[TB] FAIL rxFrame got byte=%h stop=%b required byte=%h stop=1",
                       rxSh, tx, expB);
            end
            rxLog.push_back(rxSh);
            rxPos = -1;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit w, input logic [7:0] d, input bit c, input bit r);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    clr_ovf = c;
    rst     = r;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin : mainProc
    int rxBase, doneBase, wCyc, guard;
    logic [7:0] seq3[3];
    seq3[0] = 8'h00; seq3[1] = 8'hFF; seq3[2] = 8'h55;

    // Reset then idle
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    idleCycles(50);
    checkOutput("idleTx",    32'(tx),         32'd1);
    checkOutput("idleBusy",  32'(busy),       32'd0);
    checkOutput("idleEmpty", 32'(fifo_empty), 32'd1);
    checkOutput("idleCount", 32'(fifo_count), 32'd0);
    checkOutput("idleOvf",   32'(overflow),   32'd0);

    // Single byte 0xA5 with latency pins
    rxBase = rxLog.size(); doneBase = doneLog.size();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    wCyc = cycleNo;
    checkOutput("singleEmptyAfterWrite", 32'(fifo_empty), 32'd0);
    checkOutput("singleTxStillIdle",     32'(tx),         32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("singleStartBit", 32'(tx),         32'd0);
    checkOutput("singleBusy",     32'(busy),       32'd1);
    checkOutput("singleCount",    32'(fifo_count), 32'd0);
    idleCycles(170);
    checkOutput("singleRxCount", 32'(rxLog.size() - rxBase), 32'd1);
    if (rxLog.size() > rxBase) checkOutput("singleRxByte", 32'(rxLog[rxBase]), 32'hA5);
    checkOutput("singleDoneCount", 32'(doneLog.size() - doneBase), 32'd1);
    if (doneLog.size() > doneBase) checkOutput("singleDoneTime", 32'(doneLog[doneBase] - wCyc), 32'd160);
    checkOutput("singleBackIdle", 32'(busy), 32'd0);

    // Back-to-back frames
    rxBase = rxLog.size(); doneBase = doneLog.size();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, seq3[i], 1'b0, 1'b0);
    idleCycles(500);
    checkOutput("b2bRxCount", 32'(rxLog.size() - rxBase), 32'd3);
    for (int i = 0; i < 3 && rxBase + i < rxLog.size(); i++)
      checkOutput("b2bRxByte", 32'(rxLog[rxBase+i]), 32'(seq3[i]));
    checkOutput("b2bDoneCount", 32'(doneLog.size() - doneBase), 32'd3);
    for (int i = 1; i < 3 && doneBase + i < doneLog.size(); i++)
      checkOutput("b2bDoneSpacing", 32'(doneLog[doneBase+i] - doneLog[doneBase+i-1]), 32'd160);
    checkOutput("b2bFinalEmpty", 32'(fifo_empty), 32'd1);

    // Overflow and clear
    rxBase = rxLog.size();
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("ovfFull",  32'(fifo_full),  32'd1);
    checkOutput("ovfSet",   32'(overflow),   32'd1);
    checkOutput("ovfCount", 32'(fifo_count), 32'd4);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("ovfCleared", 32'(overflow), 32'd0);
    idleCycles(5 * FRAME + 20);
    checkOutput("ovfRxCount", 32'(rxLog.size() - rxBase), 32'd5);
    for (int i = 0; i < 5 && rxBase + i < rxLog.size(); i++)
      checkOutput("ovfRxByte", 32'(rxLog[rxBase+i]), 32'(i + 1));

    // Wrap-around with the writer pacing on fifo_full
    rxBase = rxLog.size();
    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (fifo_full === 1'b1 && guard < 2000) begin
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        guard++;
      end
      checkOutput("wrapPaceNotFull", 32'(fifo_full), 32'd0);
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    idleCycles(10 * FRAME + 50);
    checkOutput("wrapRxCount", 32'(rxLog.size() - rxBase), 32'd10);
    for (int i = 0; i < 10 && rxBase + i < rxLog.size(); i++)
      checkOutput("wrapRxByte", 32'(rxLog[rxBase+i]), 32'(8'h10 + i));

    // Reset during data bit 3 with two bytes still queued
    rxBase = rxLog.size(); doneBase = doneLog.size();
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    idleCycles(66);
    checkOutput("midBitThreeLevel", 32'(tx), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("midRstTx",    32'(tx),         32'd1);
    checkOutput("midRstCount", 32'(fifo_count), 32'd0);
    checkOutput("midRstBusy",  32'(busy),       32'd0);
    idleCycles(400);
    checkOutput("midRstNoFrames", 32'(rxLog.size() - rxBase), 32'd0);
    checkOutput("midRstNoDone",   32'(doneLog.size() - doneBase), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 99) < 4, 8'($urandom), $urandom_range(0, 49) == 0,
                    $urandom_range(0, 999) == 0);
    guard = 0;
    while ((busy !== 1'b0 || fifo_empty !== 1'b1) && guard < 2000) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("randDrainBusy",  32'(busy),       32'd0);
    checkOutput("randDrainEmpty", 32'(fifo_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
